// File: rtl/mem_transfer_reader_a.sv
// mem_transfer_reader_a
// Holds a small local memory (MemA). In IDLE it can be loaded one word per
// LoadEn strobe. On Start it streams every word, in address order, to a
// B-side write counter. The B side can stall the stream with Hold.
//
// State table
//   state | meaning
//   IDLE  | loading MemA on LoadEn; B address held cleared
//   XFER  | streaming MemA[AddrA] to B; Hold stalls the stream
//   DONE  | one-cycle completion pulse, B held
//
// Ports
//   clock    : single clock, rising edge
//   Reset    : synchronous, active-high; does not touch MemA contents
//   LoadEn   : writes DataInA to MemA[AddrA] and advances AddrA (IDLE only)
//   DataInA  : load data for MemA
//   Start    : single-cycle transfer request (IDLE only, wins over LoadEn)
//   Hold     : B-side stall request during XFER
//   DataOutB : word presented to B
//   WEB      : B write enable
//   IncB     : B control (WEB/IncB = 1/0 write+inc, 0/1 hold, 0/0 clear)
//   AddrA    : current MemA address
//   Busy     : high while in XFER
//   Done     : one-cycle completion pulse
module mem_transfer_reader_a #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              LoadEn,
   input  logic [DATA_W-1:0] DataInA,
   input  logic              Start,
   input  logic              Hold,
   output logic [DATA_W-1:0] DataOutB,
   output logic              WEB,
   output logic              IncB,
   output logic [ADDR_W-1:0] AddrA,
   output logic              Busy,
   output logic              Done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            nextState;
   logic [ADDR_W-1:0] nextAddr;
   logic              memWe;
   logic [DATA_W-1:0] MemA [DEPTH];

   always_ff @(posedge clock) begin
      if (Reset) begin
         state <= IDLE;
         AddrA <= '0;
      end else begin
         state <= nextState;
         AddrA <= nextAddr;
      end
   end

   // No reset on the array: contents must survive Reset.
   always_ff @(posedge clock) begin
      if (memWe) begin
         MemA[AddrA] <= DataInA;
      end
   end

   always_comb begin
      nextState = state;
      nextAddr  = AddrA;
      memWe     = 1'b0;
      DataOutB  = '0;
      WEB       = 1'b0;
      IncB      = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;

      case (state)
         IDLE: begin
            if (Start) begin
               nextAddr  = '0;
               nextState = XFER;
            end else if (LoadEn) begin
               memWe    = ~Reset;
               nextAddr = AddrA + ADDR_W'(1);
            end
         end
         XFER: begin
            if (!Hold) begin
               if (AddrA == LAST_ADDR) begin
                  nextAddr  = '0;
                  nextState = DONE;
               end else begin
                  nextAddr = AddrA + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
            nextAddr  = '0;
         end
      endcase

      // While Reset is asserted the outputs already look like IDLE, so an
      // aborted transfer never emits a write or a Done in the reset cycle.
      if (!Reset) begin
         case (state)
            XFER: begin
               Busy     = 1'b1;
               DataOutB = MemA[AddrA];
               if (Hold) begin
                  IncB = 1'b1;
               end else begin
                  WEB = 1'b1;
               end
            end
            DONE: begin
               Done = 1'b1;
               IncB = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_transfer_reader_a.sv
module tb_mem_transfer_reader_a;

   logic       clock;
   logic       Reset;
   logic       LoadEn;
   logic [7:0] DataInA;
   logic       Start;
   logic       Hold;
   logic [7:0] DataOutB;
   logic       WEB;
   logic       IncB;
   logic [1:0] AddrA;
   logic       Busy;
   logic       Done;

   int checks = 0;
   int errors = 0;

   logic [7:0] expWrites[$];
   int         expDone[$];
   logic [7:0] memModel[4];

   mem_transfer_reader_a #(.DATA_W(8), .ADDR_W(2)) dut (
      .clock   (clock),
      .Reset   (Reset),
      .LoadEn  (LoadEn),
      .DataInA (DataInA),
      .Start   (Start),
      .Hold    (Hold),
      .DataOutB(DataOutB),
      .WEB     (WEB),
      .IncB    (IncB),
      .AddrA   (AddrA),
      .Busy    (Busy),
      .Done    (Done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chkIdle(input string tag);
      chk({tag, "_busy"}, Busy, 0);
      chk({tag, "_done"}, Done, 0);
      chk({tag, "_web"}, WEB, 0);
      chk({tag, "_incb"}, IncB, 0);
      chk({tag, "_dout"}, DataOutB, 0);
   endtask

   // Monitor: consumes expected B writes and Done pulses as the DUT shows them.
   initial begin
      forever begin
         @(negedge clock);
         if (WEB && IncB) begin
            chk("web_incb_both_high", 1, 0);
         end
         if (WEB) begin
            if (expWrites.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got %0h expected none at %0t", DataOutB, $time);
            end else begin
               chk("write_data", DataOutB, expWrites.pop_front());
            end
         end
         if (Busy && IncB && expWrites.size() > 0) begin
            chk("hold_data", DataOutB, expWrites[0]);
         end
         if (Done) begin
            checks++;
            if (expDone.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
            end else begin
               void'(expDone.pop_front());
            end
         end
      end
   end

   // Runs one full transfer. holdAt < 0 means no stall; poke drives Start,
   // LoadEn and Hold high during the transfer/DONE cycles where they must be
   // ignored; ldStart raises LoadEn together with Start.
   task automatic runTransfer(input int holdAt, input int holdLen, input bit poke, input bit ldStart);
      int doneCyc;
      int mAddr;
      int held;
      for (int i = 0; i < 4; i++) expWrites.push_back(memModel[i]);
      expDone.push_back(1);
      Start   = 1'b1;
      LoadEn  = ldStart;
      DataInA = 8'h99;
      step();
      Start   = 1'b0;
      LoadEn  = 1'b0;
      doneCyc = 5 + ((holdAt >= 0) ? holdLen : 0);
      mAddr   = 0;
      held    = 0;
      for (int cyc = 1; cyc <= doneCyc; cyc++) begin
         Hold    = (cyc < doneCyc && mAddr == holdAt && held < holdLen);
         Start   = poke;
         LoadEn  = poke;
         DataInA = 8'hEE;
         if (cyc == doneCyc) Hold = poke;
         @(negedge clock);
         chk("xfer_busy", Busy, (cyc < doneCyc));
         chk("xfer_done", Done, (cyc == doneCyc));
         chk("xfer_addr", AddrA, mAddr[1:0]);
         if (cyc == doneCyc) begin
            chk("done_incb", IncB, 1);
            chk("done_web", WEB, 0);
            chk("done_dout", DataOutB, 0);
         end else if (Hold) begin
            held++;
            chk("hold_incb", IncB, 1);
            chk("hold_web", WEB, 0);
         end else begin
            chk("xfer_web", WEB, 1);
            chk("xfer_incb", IncB, 0);
            mAddr = (mAddr + 1) % 4;
         end
         step();
      end
      Start  = 1'b0;
      LoadEn = 1'b0;
      Hold   = 1'b0;
      @(negedge clock);
      chkIdle("after_done");
      chk("after_done_addr", AddrA, 0);
   endtask

   initial begin
      memModel[0] = 8'h11;
      memModel[1] = 8'h22;
      memModel[2] = 8'h33;
      memModel[3] = 8'h44;
      Reset   = 1'b1;
      LoadEn  = 1'b0;
      DataInA = 8'h00;
      Start   = 1'b0;
      Hold    = 1'b0;
      step();
      step();
      @(negedge clock);
      chkIdle("reset");
      chk("reset_addr", AddrA, 0);

      // Reset overrides LoadEn/Start/Hold.
      LoadEn = 1'b1;
      Start  = 1'b1;
      Hold   = 1'b1;
      step();
      @(negedge clock);
      chkIdle("reset_override");
      chk("reset_override_addr", AddrA, 0);
      LoadEn = 1'b0;
      Start  = 1'b0;
      Hold   = 1'b0;
      Reset  = 1'b0;
      step();

      // Load 0x11..0x44; AddrA steps 1,2,3,0.
      for (int i = 0; i < 4; i++) begin
         LoadEn  = 1'b1;
         DataInA = memModel[i];
         step();
         chk("load_addr", AddrA, (i + 1) % 4);
      end
      LoadEn = 1'b0;
      step();

      runTransfer(-1, 0, 1'b0, 1'b0);
      step();
      runTransfer(1, 2, 1'b0, 1'b0);
      step();
      runTransfer(-1, 0, 1'b1, 1'b0);
      step();
      runTransfer(-1, 0, 1'b0, 1'b0);
      step();

      // Reload addr 0 (AddrA -> 1), then LoadEn with Start must not write addr 1.
      LoadEn  = 1'b1;
      DataInA = 8'h11;
      step();
      LoadEn  = 1'b0;
      chk("reload_addr", AddrA, 1);
      runTransfer(-1, 0, 1'b0, 1'b1);
      step();

      // Reset in the 3rd XFER cycle aborts: two writes, no Done.
      expWrites.push_back(8'h11);
      expWrites.push_back(8'h22);
      Start = 1'b1;
      step();
      Start = 1'b0;
      @(negedge clock);
      chk("abort_c1_busy", Busy, 1);
      step();
      step();
      Reset = 1'b1;
      @(negedge clock);
      chkIdle("abort_during_reset");
      step();
      Reset = 1'b0;
      @(negedge clock);
      chkIdle("abort_after");
      chk("abort_addr", AddrA, 0);
      chk("abort_writes_left", expWrites.size(), 0);
      step();
      step();
      runTransfer(-1, 0, 1'b0, 1'b0);

      step();
      step();
      chk("writes_left", expWrites.size(), 0);
      chk("done_left", expDone.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_transfer_reader_a.md
MEM_TRANSFER_READER_A -- requirements
Module: mem_transfer_reader_a

Interface
REQ-001 Parameter: DATA_W, default 8, width of each memory word and of the data path toward memory B.
REQ-002 Parameter: ADDR_W, default 2, address width; memory depth SHALL be 2**ADDR_W (4 entries).
REQ-003 Port: clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port: Reset  input  1  reset, synchronous and active-high.
REQ-005 Port: LoadEn  input  1  load strobe; writes DataInA into local memory A.
REQ-006 Port: DataInA  input  DATA_W  load data for memory A.
REQ-007 Port: Start  input  1  single-cycle request to stream all of memory A to memory B.
REQ-008 Port: Hold  input  1  stall request from the B side during a transfer.
REQ-009 Port: DataOutB  output  DATA_W  word presented to the B-side write counter.
REQ-010 Port: WEB  output  1  B-side write enable.
REQ-011 Port: IncB  output  1  B-side control, encoded as follows:
  - IncB=0, WEB=1: write, then increment B address.
  - IncB=1, WEB=0: hold B.
  - IncB=0, WEB=0: clear B address.
REQ-012 Port: AddrA  output  ADDR_W  current memory A address.
REQ-013 Port: Busy  output  1  high while in XFER.
REQ-014 Port: Done  output  1  one-cycle completion pulse.

Function
REQ-015 The block SHALL contain an internal array MemA of 2**ADDR_W words of DATA_W bits.
REQ-016 The FSM SHALL have exactly three states: IDLE, XFER, DONE.
REQ-017 IDLE, LoadEn=1, Start=0: the edge SHALL write MemA[AddrA]<=DataInA and set AddrA<=AddrA+1 mod 2**ADDR_W (3 wraps to 0).
REQ-018 IDLE, Start=1: the edge SHALL set AddrA<=0 and go to XFER; LoadEn SHALL be ignored that cycle (Start has priority).
REQ-019 IDLE outputs: WEB=0, IncB=0 (clears B address), DataOutB=0, Busy=0, Done=0.
REQ-020 XFER, Hold=0 outputs (combinational from AddrA): WEB=1, IncB=0, DataOutB=MemA[AddrA], Busy=1.
REQ-021 XFER, Hold=0, edge: AddrA<=AddrA+1; when AddrA==2**ADDR_W-1, go to DONE and set AddrA<=0.
REQ-022 XFER, Hold=1: outputs WEB=0, IncB=1, DataOutB=MemA[AddrA]; AddrA and state SHALL be unchanged.
REQ-023 XFER: Start and LoadEn SHALL be ignored; MemA SHALL NOT be written.
REQ-024 DONE SHALL last exactly one cycle with Done=1, WEB=0, IncB=1, Busy=0, DataOutB=0, then return to IDLE unconditionally.
REQ-025 DONE: Start, LoadEn and Hold SHALL be ignored.
REQ-026 With Hold held low, Start sampled at edge n SHALL give writes to B in cycles n+1..n+4 (addresses 0..3 in order) and Done=1 in cycle n+5.
REQ-027 Each Hold cycle SHALL extend the transfer by exactly one cycle; no word SHALL be skipped or repeated.
REQ-028 WEB and IncB SHALL never both be 1 in any state.

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE and AddrA=0, overriding LoadEn, Start and Hold.
REQ-030 During and after Reset, Busy=0, Done=0, WEB=0, IncB=0, DataOutB=0.
REQ-031 Reset SHALL NOT clear MemA contents.
REQ-032 Reset asserted mid-XFER SHALL abort the transfer with no Done pulse; the next cycle drives IDLE outputs.

Verification
REQ-033 Reset, then load 0x11,0x22,0x33,0x44 (LoadEn 4 cycles) -> AddrA steps 1,2,3,0; MemA holds 0x11..0x44 at addresses 0..3.
REQ-034 Start, Hold=0 -> WEB=1/IncB=0 for 4 cycles with DataOutB 0x11,0x22,0x33,0x44; Done=1 in the 5th cycle; IDLE in the 6th.
REQ-035 Start, Hold=1 for 2 cycles while AddrA=1 -> WEB=0/IncB=1 with DataOutB=0x22 held for those cycles; then 0x22,0x33,0x44 written; Done 2 cycles later than REQ-034.
REQ-036 LoadEn=1 and Start=1 in the same IDLE cycle -> no MemA write; transfer starts at address 0.
REQ-037 Reset asserted in the 3rd XFER cycle -> next cycle WEB=0, IncB=0, Busy=0, AddrA=0, no Done; MemA contents still 0x11..0x44 on a following transfer.
REQ-038 Start pulsed during XFER and during DONE -> ignored; exactly 4 writes occur and exactly one Done pulse.
